// File: rtl/i2c_master_ctrl.sv
// Single-master I2C sequencer: START, address byte, ACK, one data byte, ACK/NACK, STOP.
// Define I2C_CLK_STRETCH_EN to let a slave stretch SCL (quarter counter holds in Q2 while scl_i is low).
module i2c_master_ctrl #(
    parameter int CLK_DIV   = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       reset_in,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i,
    input  logic       scl_i
);
    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WRITE, WACK, READ, RACK, STOP, DONE
    } state_t;

    localparam logic [7:0] QCNT_MAX = 8'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] qcnt_q, qcnt_d;
    logic [1:0] quarter_q, quarter_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] addr_byte_q, addr_byte_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       nack_q, nack_d;
    logic       cmd_ready_q, cmd_ready_d;
    logic       busy_q, busy_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;
    logic       rsp_nack_q, rsp_nack_d;
    logic       scl_oe_q, scl_oe_d;
    logic       sda_oe_q, sda_oe_d;

    logic       active, hold, tick, bit_end, sample;
    logic [2:0] rx_idx, tx_idx;

`ifndef I2C_CLK_STRETCH_EN
    logic scl_i_unused;
    assign scl_i_unused = scl_i;
`endif

    always_comb begin
        active = (state_q != IDLE) && (state_q != DONE);
        hold   = 1'b0;
`ifdef I2C_CLK_STRETCH_EN
        hold   = (quarter_q == 2'd2) && (qcnt_q == 8'd0) && !scl_i;
`endif
        tick    = active && !hold && (qcnt_q == QCNT_MAX);
        bit_end = tick && (quarter_q == 2'd3);
        sample  = tick && (quarter_q == 2'd2);
        rx_idx  = LSB_FIRST ? bitcnt_q : 3'd7 - bitcnt_q;

        qcnt_d      = qcnt_q;
        quarter_d   = quarter_q;
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        addr_byte_d = addr_byte_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        nack_d      = nack_q;

        // Quarter wraps to 0 at each bit end, so IDLE always starts from a clean count.
        if (active && !hold) begin
            if (tick) begin
                qcnt_d    = 8'd0;
                quarter_d = quarter_q + 2'd1;
            end else begin
                qcnt_d = qcnt_q + 8'd1;
            end
        end

        case (state_q)
            IDLE: if (cmd_valid) begin
                state_d     = START;
                addr_byte_d = {cmd_addr, cmd_rw};
                wdata_d     = cmd_wdata;
                rdata_d     = 8'd0;
                nack_d      = 1'b0;
            end
            START: if (bit_end) state_d = ADDR;
            ADDR: if (bit_end) begin
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) state_d = ADDR_ACK;
            end
            ADDR_ACK: begin
                if (sample && sda_i) nack_d = 1'b1;
                if (bit_end) state_d = nack_q ? STOP : (addr_byte_q[0] ? READ : WRITE);
            end
            WRITE: if (bit_end) begin
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) state_d = WACK;
            end
            WACK: begin
                if (sample && sda_i) nack_d = 1'b1;
                if (bit_end) state_d = STOP;
            end
            READ: begin
                if (sample) rdata_d[rx_idx] = sda_i;
                if (bit_end) begin
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = RACK;
                end
            end
            RACK: if (bit_end) state_d = STOP;
            STOP: if (bit_end) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        rsp_valid_d = (state_d == DONE);
        rsp_rdata_d = rsp_rdata_q;
        rsp_nack_d  = rsp_nack_q;
        if (state_d == DONE) begin
            rsp_rdata_d = rdata_q;
            rsp_nack_d  = nack_q;
        end

        // Pin drive is decoded from next-state counters so the registered pins line up with them.
        tx_idx   = LSB_FIRST ? bitcnt_d : 3'd7 - bitcnt_d;
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
        case (state_d)
            START: sda_oe_d = quarter_d[1];
            ADDR: begin
                scl_oe_d = !quarter_d[1];
                sda_oe_d = !addr_byte_q[tx_idx];
            end
            WRITE: begin
                scl_oe_d = !quarter_d[1];
                sda_oe_d = !wdata_q[tx_idx];
            end
            ADDR_ACK, WACK, READ, RACK: scl_oe_d = !quarter_d[1];
            STOP: begin
                scl_oe_d = (quarter_d == 2'd0);
                sda_oe_d = !quarter_d[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= IDLE;
            qcnt_q      <= 8'd0;
            quarter_q   <= 2'd0;
            bitcnt_q    <= 3'd0;
            addr_byte_q <= 8'd0;
            wdata_q     <= 8'd0;
            rdata_q     <= 8'd0;
            nack_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'd0;
            rsp_nack_q  <= 1'b0;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            qcnt_q      <= qcnt_d;
            quarter_q   <= quarter_d;
            bitcnt_q    <= bitcnt_d;
            addr_byte_q <= addr_byte_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            nack_q      <= nack_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_nack_q  <= rsp_nack_d;
            scl_oe_q    <= scl_oe_d;
            sda_oe_q    <= sda_oe_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_nack  = rsp_nack_q;
    assign scl_oe    = scl_oe_q;
    assign sda_oe    = sda_oe_q;
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a small bit-level slave model on the open-drain bus.
module tb_i2c_master_ctrl;
    logic       clk = 1'b0;
    logic       reset_in = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [6:0] cmd_addr = 7'd0;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       cmd_ready, rsp_valid, rsp_nack, busy, scl_oe, sda_oe, sda_i, scl_i;
    logic [7:0] rsp_rdata;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // slave model configuration (written by tests) and state (written by the monitor)
    logic        slv_ack_addr = 1'b1;
    logic        slv_ack_data = 1'b1;
    logic [7:0]  slv_rdata = 8'd0;
    logic        stretch_low = 1'b0;
    logic        slave_pull = 1'b0;
    logic        prev_scl = 1'b1;
    logic        prev_sda = 1'b1;
    int          nrise = 0;
    logic [31:0] wire_bits = 32'd0;
    int          starts = 0;
    int          stops = 0;

    logic scl_bus, sda_bus;
    assign scl_bus = ~scl_oe & ~stretch_low;
    assign sda_bus = ~(sda_oe | slave_pull);
    assign sda_i   = sda_bus;
    assign scl_i   = scl_bus;

    i2c_master_ctrl #(.CLK_DIV(4), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .reset_in(reset_in),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
        .busy(busy), .scl_oe(scl_oe), .sda_oe(sda_oe),
        .sda_i(sda_i), .scl_i(scl_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bit index counts SCL rises since START: 0-7 address, 8 ACK, 9-16 data, 17 ACK/RACK.
    function automatic logic want_pull(input int idx);
        if (idx == 8) return slv_ack_addr;
        if (!slv_ack_addr) return 1'b0;
        if (wire_bits[0]) return (idx >= 9 && idx <= 16) ? !slv_rdata[idx-9] : 1'b0;
        return (idx == 17) && slv_ack_data;
    endfunction

    always @(negedge clk) begin
        if (reset_in) begin
            slave_pull <= 1'b0;
            nrise      <= 0;
            prev_scl   <= 1'b1;
            prev_sda   <= 1'b1;
        end else begin
            prev_scl <= scl_bus;
            prev_sda <= sda_bus;
            if (prev_scl && scl_bus && prev_sda && !sda_bus) begin
                starts <= starts + 1;
                nrise  <= 0;
            end
            if (prev_scl && scl_bus && !prev_sda && sda_bus) stops <= stops + 1;
            if (!prev_scl && scl_bus) begin
                if (nrise < 32) wire_bits[nrise] <= sda_bus;
                nrise <= nrise + 1;
            end
            if (prev_scl && !scl_bus) slave_pull <= want_pull(nrise);
        end
    end

    // Issues one command from a negedge and returns at the negedge where rsp_valid is seen.
    task automatic run_cmd(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                           input bit hold_v, output int acc_cyc, output int done_cyc);
        int guard;
        cmd_addr = a; cmd_rw = rw; cmd_wdata = wd; cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 1000) begin @(negedge clk); guard++; end
        acc_cyc = cyc;
        @(negedge clk);
        cmd_addr = ~a; cmd_rw = ~rw; cmd_wdata = ~wd;
        if (!hold_v) cmd_valid = 1'b0;
        guard = 0;
        while (!rsp_valid && guard < 3000) begin @(negedge clk); guard++; end
        done_cyc = rsp_valid ? cyc : -100000;
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (rsp_rdata !== 8'h00) begin bad++; $display("FAIL reset_rsp_rdata got=%h want=00", rsp_rdata); end
        total++; if (rsp_nack !== 1'b0) begin bad++; $display("FAIL reset_rsp_nack got=%b want=0", rsp_nack); end
        total++; if ({scl_oe, sda_oe} !== 2'b00) begin bad++; $display("FAIL reset_bus got=%b want=00", {scl_oe, sda_oe}); end
        reset_in = 1'b0;
        repeat (2) @(negedge clk);
        total++; if ({cmd_ready, busy, scl_oe, sda_oe} !== 4'b1000) begin bad++; $display("FAIL idle_after_reset got=%b want=1000", {cmd_ready, busy, scl_oe, sda_oe}); end
    endtask

    task automatic test_write();
        int a0, d0, s0, p0;
        slv_ack_addr = 1'b1; slv_ack_data = 1'b1;
        s0 = starts; p0 = stops;
        run_cmd(7'h25, 1'b0, 8'hA5, 1'b0, a0, d0);
        total++; if (d0 - a0 !== 321) begin bad++; $display("FAIL wr_latency got=%0d want=321", d0 - a0); end
        total++; if (rsp_nack !== 1'b0) begin bad++; $display("FAIL wr_nack got=%b want=0", rsp_nack); end
        total++; if (rsp_rdata !== 8'h00) begin bad++; $display("FAIL wr_rdata got=%h want=00", rsp_rdata); end
        total++; if (wire_bits[7:0] !== 8'b01001010) begin bad++; $display("FAIL wr_addr_bits got=%b want=01001010", wire_bits[7:0]); end
        total++; if (wire_bits[16:9] !== 8'b10100101) begin bad++; $display("FAIL wr_data_bits got=%b want=10100101", wire_bits[16:9]); end
        total++; if ({wire_bits[8], wire_bits[17]} !== 2'b00) begin bad++; $display("FAIL wr_ack_bits got=%b want=00", {wire_bits[8], wire_bits[17]}); end
        total++; if (nrise !== 19) begin bad++; $display("FAIL wr_scl_pulses got=%0d want=19", nrise); end
        total++; if ({starts - s0, stops - p0} !== {32'd1, 32'd1}) begin bad++; $display("FAIL wr_start_stop got=%0d/%0d want=1/1", starts - s0, stops - p0); end
        @(negedge clk);
        total++; if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin bad++; $display("FAIL wr_after_done got=%b want=010", {rsp_valid, cmd_ready, busy}); end
    endtask

    task automatic test_read();
        int a0, d0, p0;
        slv_ack_addr = 1'b1; slv_rdata = 8'h3C;
        p0 = stops;
        run_cmd(7'h25, 1'b1, 8'h00, 1'b0, a0, d0);
        total++; if (d0 - a0 !== 321) begin bad++; $display("FAIL rd_latency got=%0d want=321", d0 - a0); end
        total++; if (rsp_rdata !== 8'h3C) begin bad++; $display("FAIL rd_rdata got=%h want=3c", rsp_rdata); end
        total++; if (rsp_nack !== 1'b0) begin bad++; $display("FAIL rd_nack got=%b want=0", rsp_nack); end
        total++; if (wire_bits[0] !== 1'b1) begin bad++; $display("FAIL rd_rw_first got=%b want=1", wire_bits[0]); end
        total++; if (wire_bits[17] !== 1'b1) begin bad++; $display("FAIL rd_rack_released got=%b want=1", wire_bits[17]); end
        total++; if (stops - p0 !== 1) begin bad++; $display("FAIL rd_stop got=%0d want=1", stops - p0); end
        @(negedge clk);
        total++; if (rsp_rdata !== 8'h3C) begin bad++; $display("FAIL rd_rdata_held got=%h want=3c", rsp_rdata); end
    endtask

    task automatic test_addr_nack();
        int a0, d0, p0;
        slv_ack_addr = 1'b0;
        p0 = stops;
        run_cmd(7'h50, 1'b0, 8'hFF, 1'b0, a0, d0);
        total++; if (d0 - a0 !== 177) begin bad++; $display("FAIL nack_latency got=%0d want=177", d0 - a0); end
        total++; if (rsp_nack !== 1'b1) begin bad++; $display("FAIL nack_flag got=%b want=1", rsp_nack); end
        total++; if (rsp_rdata !== 8'h00) begin bad++; $display("FAIL nack_rdata got=%h want=00", rsp_rdata); end
        total++; if (nrise !== 10) begin bad++; $display("FAIL nack_scl_pulses got=%0d want=10", nrise); end
        total++; if (stops - p0 !== 1) begin bad++; $display("FAIL nack_stop got=%0d want=1", stops - p0); end
        slv_ack_addr = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        int pulses, a0, d0;
        cmd_addr = 7'h25; cmd_rw = 1'b0; cmd_wdata = 8'hA5; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        // now in cycle accept+1; data bit 1 (a 0) Q0 spans accept+177..180
        repeat (177) @(negedge clk);
        total++; if ({scl_oe, sda_oe, busy} !== 3'b111) begin bad++; $display("FAIL mid_pre_reset got=%b want=111", {scl_oe, sda_oe, busy}); end
        #2 reset_in = 1'b1;
        #1;
        total++; if ({scl_oe, sda_oe} !== 2'b00) begin bad++; $display("FAIL mid_bus_release got=%b want=00", {scl_oe, sda_oe}); end
        total++; if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin bad++; $display("FAIL mid_status got=%b want=100", {cmd_ready, busy, rsp_valid}); end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin @(negedge clk); pulses += int'(rsp_valid); end
        reset_in = 1'b0;
        for (int i = 0; i < 200; i++) begin @(negedge clk); pulses += int'(rsp_valid); end
        total++; if (pulses !== 0) begin bad++; $display("FAIL mid_no_rsp got=%0d want=0", pulses); end
        run_cmd(7'h25, 1'b0, 8'hA5, 1'b0, a0, d0);
        total++; if (d0 - a0 !== 321) begin bad++; $display("FAIL mid_recover_latency got=%0d want=321", d0 - a0); end
        total++; if ({rsp_nack, wire_bits[16:9]} !== {1'b0, 8'hA5}) begin bad++; $display("FAIL mid_recover_data got=%b want=010100101", {rsp_nack, wire_bits[16:9]}); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int a0, d0, a1, d1, s0, p0;
        s0 = starts; p0 = stops;
        run_cmd(7'h25, 1'b0, 8'hA5, 1'b1, a0, d0);
        total++; if (d0 - a0 !== 321) begin bad++; $display("FAIL b2b_lat1 got=%0d want=321", d0 - a0); end
        total++; if ({wire_bits[7:0], wire_bits[16:9]} !== 16'h4AA5) begin bad++; $display("FAIL b2b_bits1 got=%h want=4aa5", {wire_bits[7:0], wire_bits[16:9]}); end
        cmd_addr = 7'h1A; cmd_rw = 1'b0; cmd_wdata = 8'h3C;
        run_cmd(7'h1A, 1'b0, 8'h3C, 1'b0, a1, d1);
        total++; if (a1 - d0 !== 1) begin bad++; $display("FAIL b2b_accept_gap got=%0d want=1", a1 - d0); end
        total++; if (d1 - a1 !== 321) begin bad++; $display("FAIL b2b_lat2 got=%0d want=321", d1 - a1); end
        total++; if ({wire_bits[7:0], wire_bits[16:9]} !== 16'h343C) begin bad++; $display("FAIL b2b_bits2 got=%h want=343c", {wire_bits[7:0], wire_bits[16:9]}); end
        total++; if ({starts - s0, stops - p0} !== {32'd2, 32'd2}) begin bad++; $display("FAIL b2b_start_stop got=%0d/%0d want=2/2", starts - s0, stops - p0); end
        @(negedge clk);
    endtask

`ifdef I2C_CLK_STRETCH_EN
    task automatic test_stretch();
        int a0, d0;
        fork
            run_cmd(7'h25, 1'b0, 8'hA5, 1'b0, a0, d0);
            begin
                // first ADDR Q2 begins in cycle accept+25
                repeat (25) @(negedge clk);
                stretch_low = 1'b1;
                repeat (10) @(negedge clk);
                stretch_low = 1'b0;
            end
        join
        total++; if (d0 - a0 !== 331) begin bad++; $display("FAIL stretch_latency got=%0d want=331", d0 - a0); end
        total++; if ({rsp_nack, wire_bits[7:0], wire_bits[16:9]} !== {1'b0, 16'h4AA5}) begin bad++; $display("FAIL stretch_data got=%h want=04aa5", {rsp_nack, wire_bits[7:0], wire_bits[16:9]}); end
        @(negedge clk);
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_reset_mid_write();
        test_back_to_back();
`ifdef I2C_CLK_STRETCH_EN
        test_stretch();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
